// File: rtl/snow64_bfloat16_vector_fpu_sequencer_if.sv
// Signal bundle between the vector execute stage, the lane sequencer and the
// scalar BFloat16 FPU. The sequencer takes the slave view; its environment
// (execute stage plus FPU) takes the master view.
interface snow64_bfloat16_vector_fpu_sequencer_if #(
    parameter int NUM_LANES  = 16,
    parameter int ELEM_WIDTH = 16,
    parameter int OPER_WIDTH = 3
);
    // vector-side command
    logic                            in_start;
    logic [OPER_WIDTH-1:0]           in_oper;
    logic [NUM_LANES-1:0]            in_lane_mask;
    logic [NUM_LANES*ELEM_WIDTH-1:0] in_a;
    logic [NUM_LANES*ELEM_WIDTH-1:0] in_b;
    // vector-side result
    logic                            out_can_accept_cmd;
    logic                            out_data_valid;
    logic [NUM_LANES*ELEM_WIDTH-1:0] out_data;
    // scalar FPU handshake
    logic                            fpu_start;
    logic [OPER_WIDTH-1:0]           fpu_oper;
    logic [ELEM_WIDTH-1:0]           fpu_a;
    logic [ELEM_WIDTH-1:0]           fpu_b;
    logic                            fpu_can_accept_cmd;
    logic                            fpu_data_valid;
    logic [ELEM_WIDTH-1:0]           fpu_data;

    modport master (
        output in_start, in_oper, in_lane_mask, in_a, in_b,
               fpu_can_accept_cmd, fpu_data_valid, fpu_data,
        input  out_can_accept_cmd, out_data_valid, out_data,
               fpu_start, fpu_oper, fpu_a, fpu_b
    );

    modport slave (
        input  in_start, in_oper, in_lane_mask, in_a, in_b,
               fpu_can_accept_cmd, fpu_data_valid, fpu_data,
        output out_can_accept_cmd, out_data_valid, out_data,
               fpu_start, fpu_oper, fpu_a, fpu_b
    );
endinterface

// File: rtl/snow64_bfloat16_vector_fpu_sequencer.sv
// Splits one 16-lane BFloat16 vector op into scalar FPU commands, one lane at
// a time, and gathers the scalar results back into a vector result.

// One result lane: cleared when a command is accepted, written once when the
// sequencer finishes this lane. Exposes the next-state value so the top can
// snapshot the completed vector in the same cycle the last lane lands.
module snow64_bfloat16_vector_fpu_seq_lane #(
    parameter int ELEM_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  wr_i,
    input  logic [ELEM_WIDTH-1:0] wdata_i,
    output logic [ELEM_WIDTH-1:0] res_d_o
);
    logic [ELEM_WIDTH-1:0] res_q, res_d;

    // clear on accept takes priority over a lane write
    always_comb begin
        res_d = res_q;
        if (clr_i)
            res_d = '0;
        else if (wr_i)
            res_d = wdata_i;
    end

    // lane result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_q <= '0;
        else
            res_q <= res_d;
    end

    assign res_d_o = res_d;
endmodule

module snow64_bfloat16_vector_fpu_sequencer #(
    parameter int NUM_LANES  = 16,
    parameter int ELEM_WIDTH = 16,
    parameter int OPER_WIDTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    snow64_bfloat16_vector_fpu_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    // FPU oper encodings; anything else is never answered by the FPU
    localparam logic [OPER_WIDTH-1:0] OP_ADD       = OPER_WIDTH'(0);
    localparam logic [OPER_WIDTH-1:0] OP_SUB       = OPER_WIDTH'(1);
    localparam logic [OPER_WIDTH-1:0] OP_SLT       = OPER_WIDTH'(2);
    localparam logic [OPER_WIDTH-1:0] OP_MUL       = OPER_WIDTH'(3);
    localparam logic [OPER_WIDTH-1:0] OP_DIV       = OPER_WIDTH'(4);
    localparam logic [OPER_WIDTH-1:0] OP_ADD_AGAIN = OPER_WIDTH'(5);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic [OPER_WIDTH-1:0]                oper;
        logic [NUM_LANES-1:0]                 mask;
        logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] a;
        logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] b;
    } cmd_t;

    function automatic logic oper_known(input logic [OPER_WIDTH-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) ||
               (op == OP_MUL) || (op == OP_DIV) || (op == OP_ADD_AGAIN);
    endfunction

    state_t                               state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    cmd_t                                 cmd_q, cmd_d;
    logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] res_d;

    logic                  res_clr;
    logic                  res_wr;
    logic [ELEM_WIDTH-1:0] res_wdata;
    logic                  fpu_start;
    logic                  can_accept;
    logic                  last_lane;

    assign last_lane = (idx_q == LAST_IDX);

    // FSM next state, lane-write strobes and handshake outputs
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        res_clr    = 1'b0;
        res_wr     = 1'b0;
        res_wdata  = '0;
        fpu_start  = 1'b0;
        can_accept = 1'b0;
        case (state_q)
            IDLE: begin
                can_accept = 1'b1;
                if (bus.in_start) begin
                    cmd_d.oper = bus.in_oper;
                    cmd_d.mask = bus.in_lane_mask;
                    cmd_d.a    = bus.in_a;
                    cmd_d.b    = bus.in_b;
                    res_clr    = 1'b1;
                    idx_d      = '0;
                    // unknown opers finish immediately with a zero vector
                    state_d    = oper_known(bus.in_oper) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (!cmd_q.mask[idx_q]) begin
                    // disabled lane: zero it and move on, one cycle per lane
                    res_wr = 1'b1;
                    if (last_lane)
                        state_d = DONE;
                    else
                        idx_d = idx_q + IDX_W'(1);
                end else if (bus.fpu_can_accept_cmd) begin
                    fpu_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.fpu_data_valid) begin
                    res_wr    = 1'b1;
                    res_wdata = bus.fpu_data;
                    if (last_lane) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // snapshot the finished vector on entry to DONE so it holds until the
    // next command completes, independent of the working result lanes
    assign out_data_d = (state_d == DONE) ? res_d : out_data_q;

    // control and captured-command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cmd_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            out_data_q <= out_data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            snow64_bfloat16_vector_fpu_seq_lane #(
                .ELEM_WIDTH(ELEM_WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr_i   (res_clr),
                .wr_i    (res_wr && (idx_q == IDX_W'(gi))),
                .wdata_i (res_wdata),
                .res_d_o (res_d[gi])
            );
        end
    endgenerate

    assign bus.out_can_accept_cmd = can_accept;
    assign bus.out_data_valid     = (state_q == DONE);
    assign bus.out_data           = out_data_q;
    assign bus.fpu_start          = fpu_start;
    assign bus.fpu_oper           = cmd_q.oper;
    assign bus.fpu_a              = cmd_q.a[idx_q];
    assign bus.fpu_b              = cmd_q.b[idx_q];
endmodule

// File: tb/tb_snow64_bfloat16_vector_fpu_sequencer.sv
// Bench: behavioural scalar FPU (fixed latency, stallable), scoreboard of
// expected vectors, latency and start-count checks, stall and reset cases.
module tb_snow64_bfloat16_vector_fpu_sequencer;
    localparam int NL  = 16;
    localparam int EW  = 16;
    localparam int OW  = 3;
    localparam int LAT = 3;   // model pipeline; start-to-valid distance is LAT+1

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snow64_bfloat16_vector_fpu_sequencer_if #(.NUM_LANES(NL), .ELEM_WIDTH(EW), .OPER_WIDTH(OW)) bus ();

    snow64_bfloat16_vector_fpu_sequencer #(.NUM_LANES(NL), .ELEM_WIDTH(EW), .OPER_WIDTH(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_lat = 0;
    int nvalid = 0;
    int nstarts = 0;
    logic [2:0] cur_oper = 3'd0;
    logic stall = 1'b0;
    logic [255:0] sb[$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // ---------------- BFloat16 reference arithmetic ----------------
    function automatic real bf2r(input logic [15:0] x);
        real m;
        int e;
        if (x[14:0] == 15'd0) return 0.0;
        e = int'(x[14:7]) - 127;
        m = 1.0 + real'(x[6:0]) / 128.0;
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i > e; i--) m = m / 2.0;
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic s;
        int e;
        int mi;
        real v;
        logic [7:0] eb;
        logic [6:0] mb;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        v = s ? -r : r;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        mi = $rtoi((v - 1.0) * 128.0);
        eb = e[7:0];
        mb = mi[6:0];
        return {s, eb, mb};
    endfunction

    function automatic logic [15:0] fpu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        real ra, rb;
        ra = bf2r(a);
        rb = bf2r(b);
        case (op)
            3'd0, 3'd5: return r2bf(ra + rb);
            3'd1:       return r2bf(ra - rb);
            3'd2:       return (ra < rb) ? 16'h0001 : 16'h0000;
            3'd3:       return r2bf(ra * rb);
            3'd4:       return (rb == 0.0) ? 16'h0000 : r2bf(ra / rb);
            default:    return 16'h0000;
        endcase
    endfunction

    function automatic logic [255:0] exp_vec(input logic [2:0] op, input logic [15:0] m,
                                             input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        r = '0;
        if (op <= 3'd5)
            for (int i = 0; i < NL; i++)
                if (m[i]) r[i*16 +: 16] = fpu_ref(op, a[i*16 +: 16], b[i*16 +: 16]);
        return r;
    endfunction

    // ---------------- scalar FPU model (not reset with the DUT) ----------------
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_res = 16'h0;
    assign bus.fpu_can_accept_cmd = !m_busy && !stall;

    always @(posedge clk) begin
        bus.fpu_data_valid <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 1) begin
                bus.fpu_data_valid <= 1'b1;
                bus.fpu_data       <= m_res;
                m_busy             <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end else if (bus.fpu_start && bus.fpu_can_accept_cmd) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            m_res  <= fpu_ref(bus.fpu_oper, bus.fpu_a, bus.fpu_b);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (rst_n && bus.in_start && bus.out_can_accept_cmd) acc_cyc = cyc;
        if (bus.fpu_start) begin
            nstarts++;
            chk("start_when_busy", bus.fpu_can_accept_cmd, 1);
            chk("start_oper", bus.fpu_oper, cur_oper);
        end
        if (bus.out_data_valid) begin
            nvalid++;
            last_lat = cyc - acc_cyc + 1;
            if (sb.size() == 0) chk("spurious_valid", sb.size(), 1);
            else chk("out_data", bus.out_data, sb.pop_front());
        end
    end

    task automatic run_cmd(input logic [2:0] op, input logic [15:0] mask,
                           input logic [255:0] a, input logic [255:0] b,
                           input logic [255:0] exp, input int exp_lat, input int exp_starts);
        int n;
        int v0;
        @(posedge clk); #1;
        cur_oper = op;
        nstarts = 0;
        v0 = nvalid;
        sb.push_back(exp);
        bus.in_start = 1'b1;
        bus.in_oper = op;
        bus.in_lane_mask = mask;
        bus.in_a = a;
        bus.in_b = b;
        n = 0;
        @(negedge clk);
        while (!bus.out_can_accept_cmd && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        n = 0;
        while (nvalid == v0 && n < 3000) begin @(negedge clk); n++; end
        #1;
        chk("done_count", nvalid - v0, 1);
        if (exp_lat > 0) chk("latency", last_lat, exp_lat);
        chk("start_count", nstarts, exp_starts);
    endtask

    // hold the FPU busy for 5 cycles when lane 3 is due; poke in_start meanwhile
    task automatic stall_seq();
        int n;
        n = 0;
        while (!(nstarts == 3 && bus.fpu_data_valid) && n < 500) begin @(negedge clk); n++; end
        chk("stall_reach_l3", nstarts, 3);
        stall = 1'b1;
        bus.in_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_no_start", bus.fpu_start, 0);
        end
        bus.in_start = 1'b0;
        @(posedge clk); #1;
        stall = 1'b0;
        #1;
        chk("stall_release_start", bus.fpu_start, 1);
    endtask

    logic [255:0] va, vb, ve;
    logic [15:0]  rm;
    logic [2:0]   rops[4] = '{3'd2, 3'd4, 3'd5, 3'd1};
    int           nv0, n;

    initial begin
        bus.in_start = 1'b0;
        bus.in_oper = '0;
        bus.in_lane_mask = '0;
        bus.in_a = '0;
        bus.in_b = '0;
        #2;
        chk("rst_can_accept", bus.out_can_accept_cmd, 1);
        chk("rst_valid", bus.out_data_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_fpu_start", bus.fpu_start, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // add 1.0 + 2.0 on every lane: 1 + 16*(1+4) + 1 cycles
        run_cmd(3'd0, 16'hFFFF, {16{16'h3F80}}, {16{16'h4000}}, {16{16'h4040}}, 82, 16);
        // sub 3.0 - 1.0
        run_cmd(3'd1, 16'hFFFF, {16{16'h4040}}, {16{16'h3F80}}, {16{16'h4000}}, -1, 16);
        // mul lane 0 only: 2.0 * 3.0
        run_cmd(3'd3, 16'h0001, {16{16'h4000}}, {16{16'h4040}}, {240'h0, 16'h40C0}, 22, 1);
        // empty mask
        run_cmd(3'd3, 16'h0000, {16{16'h4000}}, {16{16'h4040}}, 256'h0, 18, 0);
        // unknown oper
        run_cmd(3'd7, 16'hFFFF, {16{16'h4000}}, {16{16'h4040}}, 256'h0, 2, 0);

        // FPU stall at lane 3 with dropped in_start pulses
        fork
            run_cmd(3'd0, 16'hFFFF, {16{16'h3F80}}, {16{16'h4000}}, {16{16'h4040}}, -1, 16);
            stall_seq();
        join
        nv0 = nvalid;
        repeat (30) @(negedge clk);
        chk("no_extra_cmd", nvalid, nv0);

        // random-data ops with random masks
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NL; i++) begin
                va[i*16 +: 16] = r2bf(real'($urandom_range(1, 8)));
                vb[i*16 +: 16] = r2bf(real'($urandom_range(1, 8)));
            end
            rm = 16'($urandom);
            ve = exp_vec(rops[t], rm, va, vb);
            run_cmd(rops[t], rm, va, vb, ve, 1 + 5 * $countones(rm) + (16 - $countones(rm)) + 1, $countones(rm));
        end

        // reset while waiting on lane 7
        @(posedge clk); #1;
        cur_oper = 3'd0;
        nstarts = 0;
        nv0 = nvalid;
        bus.in_start = 1'b1;
        bus.in_oper = 3'd0;
        bus.in_lane_mask = 16'hFFFF;
        bus.in_a = {16{16'h3F80}};
        bus.in_b = {16{16'h4000}};
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        n = 0;
        while (nstarts < 8 && n < 500) begin @(negedge clk); n++; end
        chk("rst_reach_l7", nstarts, 8);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_can_accept", bus.out_can_accept_cmd, 1);
        chk("mid_rst_valid", bus.out_data_valid, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_fpu_start", bus.fpu_start, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("late_result_ignored", bus.out_data, 0);
        chk("no_pulse_after_rst", nvalid, nv0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
